// File: rtl/rv32_multicycle_system_if.sv
// -----------------------------------------------------------------------------
// rv32_multicycle_system_if
// Shared memory port between the multicycle core (master) and the unified
// instruction/data memory (slave). One access per cycle. Read data returns
// one cycle after the address is presented.
//
// Optional feature macro: STORE_EN (adds the write channel).
//
// Signals:
//   addr   master->slave  32  byte address (word index taken from addr[..:2])
//   rdata  slave->master  32  registered read data
//   wdata  master->slave  32  write data, lanes already replicated (STORE_EN)
//   be     master->slave   4  byte enables (STORE_EN)
//   we     master->slave   1  write strobe (STORE_EN)
// -----------------------------------------------------------------------------
interface rv32_multicycle_system_if;
    logic [31:0] addr;
    logic [31:0] rdata;
`ifdef STORE_EN
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
`endif

`ifdef STORE_EN
    modport master (output addr, input rdata, output wdata, output be, output we);
    modport slave  (input addr, output rdata, input wdata, input be, input we);
`else
    modport master (output addr, input rdata);
    modport slave  (input addr, output rdata);
`endif
endinterface

// File: rtl/rv32_multicycle_system.sv
// -----------------------------------------------------------------------------
// rv32_multicycle_system
// Minimal RV32I-subset multicycle processor with a unified, word-organised,
// little-endian memory. Loads (lb/lh/lw/lbu/lhu), OP, OP-IMM and beq are
// supported; stores (sb/sh/sw) only when STORE_EN is defined, otherwise they
// retire as NOPs.
//
// Optional feature macro: STORE_EN.
//
// Top ports:
//   clk    input 1  system clock, rising edge
//   reset  input 1  synchronous active-high reset (PC and FSM only; register
//                   file and memory contents are preserved)
// Parameters:
//   MEM_WORDS  depth of memory in 32-bit words (power of two, addresses wrap)
//   RESET_PC   PC loaded by reset
// -----------------------------------------------------------------------------
package rv32_ms_pkg;
    typedef enum logic [5:0] {
        FETCH      = 6'd0,
        FETCH_WAIT = 6'd1,
        DECODE     = 6'd2,
        MEMADR     = 6'd3,
        MEMREAD    = 6'd4,
        MEMWB      = 6'd5,
        EXECUTER   = 6'd7,
        EXECUTEI   = 6'd8,
        ALUWB      = 6'd9,
        BRANCH     = 6'd10
`ifdef STORE_EN
        , MEMWRITE = 6'd6
`endif
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
        ALU_XOR  = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
        ALU_SRL  = 4'd8, ALU_SRA = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Select the byte/half/word a load refers to and extend it. The sign bit is
    // the top bit of the selected field, never a neighbouring byte.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Byte-lane enables for sb/sh/sw; unknown widths write nothing.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << off;
            3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store value across lanes so the enables alone place it.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] v);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{v[7:0]}};
            3'b001:  d = {2{v[15:0]}};
            default: d = v;
        endcase
        return d;
    endfunction

    // ALU operation from funct3/funct7[5]; funct7[5] means SUB only for R-type.
    function automatic alu_op_e alu_op_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_reg);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction
endpackage

// Unified memory: synchronous read, byte-enabled write, no reset.
module rv32_ms_memory #(
    parameter int MEM_WORDS = 256
) (
    input logic                      clk_i,
    rv32_multicycle_system_if.slave  bus
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0]   M [0:MEM_WORDS-1];
    logic [31:0]   rdata_q;
    logic [AW-1:0] idx_s;
    logic          unused_addr_s;

    assign idx_s         = bus.addr[AW+1:2];
    assign unused_addr_s = ^{bus.addr[31:AW+2], bus.addr[1:0]};
    assign bus.rdata     = rdata_q;

    // Read port (one-cycle latency) and optional byte-lane write port.
    always_ff @(posedge clk_i) begin
        rdata_q <= M[idx_s];
`ifdef STORE_EN
        if (bus.we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be[i]) begin
                    M[idx_s][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
`endif
    end
endmodule

// 32x32 register file, two combinational reads, one write; x0 hardwired to 0.
module rv32_ms_regfile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] RFMem [0:31];

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : RFMem[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : RFMem[ra2_i];

    // Single write port; reset deliberately leaves contents alone.
    always_ff @(posedge clk_i) begin
        if (we_i && (wa_i != 5'd0)) begin
            RFMem[wa_i] <= wd_i;
        end
    end
endmodule

// Field extraction and immediate generation from the instruction register.
module rv32_ms_decode
    import rv32_ms_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [6:0]  opcode_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [2:0]  funct3_o,
    output logic        funct7b5_o,
    output logic [31:0] imm_ext_o
);
    logic [4:0]  rs1;
    logic [31:0] imm_ext;

    assign opcode_o   = instr_i[6:0];
    assign rd_o       = instr_i[11:7];
    assign funct3_o   = instr_i[14:12];
    assign rs1        = instr_i[19:15];
    assign rs2_o      = instr_i[24:20];
    assign funct7b5_o = instr_i[30];
    assign rs1_o      = rs1;
    assign imm_ext_o  = imm_ext;

    // Immediate format chosen by opcode (I, S or B), always sign-extended.
    always_comb begin
        imm_ext = 32'd0;
        case (instr_i[6:0])
            OPC_LOAD, OPC_OPIMM: imm_ext = {{20{instr_i[31]}}, instr_i[31:20]};
            OPC_STORE:  imm_ext = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OPC_BRANCH: imm_ext = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                   instr_i[30:25], instr_i[11:8], 1'b0};
            default:    imm_ext = 32'd0;
        endcase
    end
endmodule

// Single shared ALU.
module rv32_ms_alu
    import rv32_ms_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_e     op_i,
    output logic [31:0] out_o
);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;

    assign a     = a_i;
    assign b     = b_i;
    assign out_o = out;

    // Operation select; shifts use the low five bits of b.
    always_comb begin
        out = 32'd0;
        case (op_i)
            ALU_ADD:  out = a + b;
            ALU_SUB:  out = a - b;
            ALU_AND:  out = a & b;
            ALU_OR:   out = a | b;
            ALU_XOR:  out = a ^ b;
            ALU_SLT:  out = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU: out = {31'd0, (a < b)};
            ALU_SLL:  out = a << b[4:0];
            ALU_SRL:  out = a >> b[4:0];
            ALU_SRA:  out = $unsigned($signed(a) >>> b[4:0]);
            default:  out = 32'd0;
        endcase
    end
endmodule

// Program counter; advances only on the transition into FETCH.
module rv32_ms_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        pc_en_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_imm_i,
    output logic [31:0] pc_o
);
    logic [31:0] pc_cur;
    logic [31:0] pc_d;

    assign pc_o = pc_cur;

    // Next PC: branch target when a beq is taken, otherwise sequential.
    always_comb begin
        pc_d = pc_cur;
        if (pc_en_i) begin
            pc_d = br_taken_i ? (pc_cur + br_imm_i) : (pc_cur + 32'd4);
        end else begin
            pc_d = pc_cur;
        end
    end

    // PC register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_cur <= RESET_PC;
        end else begin
            pc_cur <= pc_d;
        end
    end
endmodule

// Control FSM; reset parks it in FETCH which aborts any instruction in flight.
module rv32_ms_control_fsm
    import rv32_ms_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output state_e     state_o,
    output state_e     next_o
);
    state_e current_state;
    state_e next_state;

    assign state_o = current_state;
    assign next_o  = next_state;

    // Next-state selection; unsupported opcodes fall straight back to FETCH.
    always_comb begin
        next_state = current_state;
        case (current_state)
            FETCH:      next_state = FETCH_WAIT;
            FETCH_WAIT: next_state = DECODE;
            DECODE: begin
                case (opcode_i)
                    OPC_LOAD:   next_state = MEMADR;
`ifdef STORE_EN
                    OPC_STORE:  next_state = MEMADR;
`endif
                    OPC_OP:     next_state = EXECUTER;
                    OPC_OPIMM:  next_state = EXECUTEI;
                    OPC_BRANCH: next_state = (funct3_i == 3'b000) ? BRANCH : FETCH;
                    default:    next_state = FETCH;
                endcase
            end
`ifdef STORE_EN
            MEMADR:     next_state = (opcode_i == OPC_STORE) ? MEMWRITE : MEMREAD;
            MEMWRITE:   next_state = FETCH;
`else
            MEMADR:     next_state = MEMREAD;
`endif
            MEMREAD:    next_state = MEMWB;
            MEMWB:      next_state = FETCH;
            EXECUTER:   next_state = ALUWB;
            EXECUTEI:   next_state = ALUWB;
            ALUWB:      next_state = FETCH;
            BRANCH:     next_state = FETCH;
            default:    next_state = FETCH;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            current_state <= FETCH;
        end else begin
            current_state <= next_state;
        end
    end
endmodule

// Multicycle core: IR, result register, datapath steering.
module rv32_ms_core
    import rv32_ms_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    rv32_multicycle_system_if.master  mem_bus
);
    state_e      state_s;
    state_e      next_s;
    logic [31:0] instr_q;
    logic [6:0]  opcode;
    logic [4:0]  rs1_s, rs2_s, rd_s;
    logic [2:0]  funct3_s;
    logic        funct7b5_s;
    logic [31:0] imm_s, rd1_s, rd2_s, pc_s;
    logic [31:0] alu_a_s, alu_b_s, alu_out_s;
    alu_op_e     alu_op_s;
    logic [31:0] result;
    logic [31:0] result_d;
    logic [31:0] data;
    logic        rf_we_s;
    logic [31:0] rf_wd_s;
    logic        br_taken_s;
    logic        pc_en_s;

    rv32_ms_control_fsm control_fsm (
        .clk_i(clk_i), .reset_i(reset_i), .opcode_i(opcode), .funct3_i(funct3_s),
        .state_o(state_s), .next_o(next_s));

    rv32_ms_decode instruction_decode (
        .instr_i(instr_q), .opcode_o(opcode), .rs1_o(rs1_s), .rs2_o(rs2_s), .rd_o(rd_s),
        .funct3_o(funct3_s), .funct7b5_o(funct7b5_s), .imm_ext_o(imm_s));

    rv32_ms_regfile RegFile (
        .clk_i(clk_i), .we_i(rf_we_s), .wa_i(rd_s), .wd_i(rf_wd_s),
        .ra1_i(rs1_s), .ra2_i(rs2_s), .rd1_o(rd1_s), .rd2_o(rd2_s));

    rv32_ms_alu alu (.a_i(alu_a_s), .b_i(alu_b_s), .op_i(alu_op_s), .out_o(alu_out_s));

    rv32_ms_fetch #(.RESET_PC(RESET_PC)) fetch (
        .clk_i(clk_i), .reset_i(reset_i), .pc_en_i(pc_en_s), .br_taken_i(br_taken_s),
        .br_imm_i(imm_s), .pc_o(pc_s));

    // Load data is the memory word returned in MEMWB, addressed by result.
    assign data       = load_extract(mem_bus.rdata, funct3_s, result[1:0]);
    assign br_taken_s = (state_s == BRANCH) && (alu_out_s == 32'd0);
    assign pc_en_s    = (next_s == FETCH) && (state_s != FETCH);
    assign rf_we_s    = !reset_i && ((state_s == MEMWB) || (state_s == ALUWB));
    assign rf_wd_s    = (state_s == MEMWB) ? data : result;

    // ALU operand/operation steering per state; beq compares via subtraction.
    always_comb begin
        alu_a_s  = rd1_s;
        alu_b_s  = imm_s;
        alu_op_s = ALU_ADD;
        case (state_s)
            EXECUTER: begin
                alu_b_s  = rd2_s;
                alu_op_s = alu_op_decode(funct3_s, funct7b5_s, 1'b1);
            end
            EXECUTEI: alu_op_s = alu_op_decode(funct3_s, funct7b5_s, 1'b0);
            BRANCH: begin
                alu_b_s  = rd2_s;
                alu_op_s = ALU_SUB;
            end
            default: begin
                alu_b_s  = imm_s;
                alu_op_s = ALU_ADD;
            end
        endcase
    end

    // Memory port: data accesses use the computed address, all else uses PC.
    always_comb begin
        mem_bus.addr = pc_s;
        case (state_s)
            MEMREAD:  mem_bus.addr = result;
`ifdef STORE_EN
            MEMWRITE: mem_bus.addr = result;
`endif
            default:  mem_bus.addr = pc_s;
        endcase
    end

`ifdef STORE_EN
    assign mem_bus.we    = !reset_i && (state_s == MEMWRITE);
    assign mem_bus.be    = store_be(funct3_s, result[1:0]);
    assign mem_bus.wdata = store_data(funct3_s, rd2_s);
`endif

    // Result register: ALU output in address/execute states, load data in MEMWB.
    always_comb begin
        result_d = result;
        case (state_s)
            MEMADR, EXECUTER, EXECUTEI: result_d = alu_out_s;
            MEMWB:                      result_d = data;
            default:                    result_d = result;
        endcase
    end

    // Instruction and result registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            instr_q <= 32'd0;
            result  <= 32'd0;
        end else begin
            if (state_s == FETCH_WAIT) begin
                instr_q <= mem_bus.rdata;
            end
            result <= result_d;
        end
    end
endmodule

// System top: core plus unified memory.
module rv32_multicycle_system #(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic reset
);
    rv32_multicycle_system_if mem_bus ();

    logic [31:0] memory__address;
    logic        unused_probe_s;

    assign memory__address = mem_bus.addr;
    assign unused_probe_s  = ^memory__address;

    rv32_ms_core #(.RESET_PC(RESET_PC)) core (
        .clk_i(clk), .reset_i(reset), .mem_bus(mem_bus.master));

    rv32_ms_memory #(.MEM_WORDS(MEM_WORDS)) memory (
        .clk_i(clk), .bus(mem_bus.slave));
endmodule

// File: tb/tb_rv32_multicycle_system.sv
module tb_rv32_multicycle_system;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    localparam logic [5:0] ST_FETCH   = 6'd0;
    localparam logic [5:0] ST_DECODE  = 6'd2;
    localparam logic [5:0] ST_MEMADR  = 6'd3;
    localparam logic [5:0] ST_MEMREAD = 6'd4;
    localparam logic [5:0] ST_MEMWB   = 6'd5;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    always #5 clk = ~clk;

    rv32_multicycle_system #(.MEM_WORDS(256), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Wait (bounded) until the FSM reaches st, sampling on negedges.
    task automatic wait_state(input logic [5:0] st, input string tag);
        int n = 0;
        while ((dut.core.control_fsm.current_state != st) && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, dut.core.control_fsm.current_state, st);
    endtask

    // Run from one FETCH to the next.
    task automatic step_instr(input string tag);
        @(negedge clk);
        wait_state(ST_FETCH, tag);
    endtask

    logic [11:0] ld_imm [0:16];
    logic [2:0]  ld_f3  [0:16];
    logic [31:0] ld_exp [0:16];
    logic [31:0] m40_after_sb, m40_after_sh;

    initial begin
        ld_imm = '{12'h090, 12'h098, 12'h09b, 12'h098, 12'h093, 12'h092, 12'h09a, 12'h098,
                   12'h0a0, 12'h0a5, 12'h0aa, 12'h0af, 12'h0a4, 12'h0a6, 12'h0a8, 12'h0aa,
                   12'h090};
        ld_f3  = '{3'd0, 3'd0, 3'd0, 3'd4, 3'd4, 3'd1, 3'd1, 3'd5,
                   3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
        ld_exp = '{32'h00000011, 32'hfffffff4, 32'hffffffc7, 32'h000000f4, 32'h00000044,
                   32'h00004433, 32'hffffc7d6, 32'h0000e5f4, 32'hffffff80, 32'hffffff80,
                   32'hffffff80, 32'hffffff80, 32'hffff8000, 32'h00000000, 32'h00000000,
                   32'h00000080, 32'h44332211};
`ifdef STORE_EN
        m40_after_sb = 32'h4433ab11;
        m40_after_sh = 32'hbeefab11;
`else
        m40_after_sb = 32'h44332211;
        m40_after_sh = 32'h44332211;
`endif
        for (int i = 0; i < 256; i++) dut.memory.M[i] = 32'd0;
        for (int i = 0; i < 32; i++) dut.core.RegFile.RFMem[i] = 32'd0;
        dut.core.RegFile.RFMem[2] = 32'h10;
        for (int i = 0; i < 17; i++) dut.memory.M[i] = enc_i(ld_imm[i], 5'd2, ld_f3[i], 5'd1, OPC_LOAD);
        dut.memory.M[17] = enc_i(12'd5, 5'd0, 3'b000, 5'd3, OPC_OPIMM);
        dut.memory.M[18] = enc_r(7'd0, 5'd3, 5'd3, 3'b000, 5'd4);
        dut.memory.M[19] = enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPC_OPIMM);
        dut.memory.M[20] = enc_b(13'd8, 5'd3, 5'd3, 3'b000);
        dut.memory.M[21] = enc_i(12'd1, 5'd0, 3'b000, 5'd6, OPC_OPIMM);
        dut.memory.M[22] = enc_i(12'd2, 5'd0, 3'b000, 5'd7, OPC_OPIMM);
        dut.memory.M[23] = enc_r(7'b0100000, 5'd4, 5'd3, 3'b000, 5'd8);
        dut.memory.M[24] = enc_i(12'h401, 5'd8, 3'b101, 5'd9, OPC_OPIMM);
        dut.memory.M[25] = enc_r(7'd0, 5'd8, 5'd3, 3'b011, 5'd10);
        dut.memory.M[26] = enc_i(12'h0ab, 5'd0, 3'b000, 5'd11, OPC_OPIMM);
        dut.memory.M[27] = enc_s(12'h091, 5'd11, 5'd2, 3'b000);
        dut.memory.M[28] = enc_i(12'h5f7, 5'd0, 3'b000, 5'd12, OPC_OPIMM);
        dut.memory.M[29] = enc_i(12'd5, 5'd12, 3'b001, 5'd12, OPC_OPIMM);
        dut.memory.M[30] = enc_i(12'h00f, 5'd12, 3'b110, 5'd12, OPC_OPIMM);
        dut.memory.M[31] = enc_s(12'h092, 5'd12, 5'd2, 3'b001);
        dut.memory.M[32] = enc_i(12'h090, 5'd2, 3'b000, 5'd1, OPC_LOAD);
        dut.memory.M[40] = 32'h44332211;
        dut.memory.M[42] = 32'hc7d6e5f4;
        dut.memory.M[44] = 32'h00000080;
        dut.memory.M[45] = 32'h00008000;
        dut.memory.M[46] = 32'h00800000;
        dut.memory.M[47] = 32'h80000000;

        // Reset held three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_state", dut.core.control_fsm.current_state, ST_FETCH);
        check_eq("rst_pc", dut.core.fetch.pc_cur, 32'h0);
        check_eq("rst_x2_kept", dut.core.RegFile.RFMem[2], 32'h10);
        reset = 1'b0;

        // First lb traced state by state.
        wait_state(ST_DECODE, "lb0_decode");
        check_eq("lb0_imm", dut.core.instruction_decode.imm_ext, 32'h90);
        wait_state(ST_MEMADR, "lb0_memadr");
        check_eq("lb0_alu_a", dut.core.alu.a, 32'h10);
        check_eq("lb0_alu_b", dut.core.alu.b, 32'h90);
        check_eq("lb0_alu_out", dut.core.alu.out, 32'ha0);
        wait_state(ST_MEMREAD, "lb0_memread");
        check_eq("lb0_memaddr", dut.memory__address, 32'ha0);
        wait_state(ST_MEMWB, "lb0_memwb");
        check_eq("lb0_data", dut.core.data, 32'h11);
        wait_state(ST_FETCH, "lb0_fetch");
        check_eq("lb0_x1", dut.core.RegFile.RFMem[1], ld_exp[0]);
        check_eq("lb0_pc", dut.core.fetch.pc_cur, 32'h4);

        for (int i = 1; i < 17; i++) begin
            step_instr($sformatf("ld%0d_done", i));
            check_eq($sformatf("ld%0d_x1", i), dut.core.RegFile.RFMem[1], ld_exp[i]);
            check_eq($sformatf("ld%0d_pc", i), dut.core.fetch.pc_cur, 32'(4 * (i + 1)));
        end

        step_instr("addi_done");
        check_eq("addi_x3", dut.core.RegFile.RFMem[3], 32'd5);
        step_instr("add_done");
        check_eq("add_x4", dut.core.RegFile.RFMem[4], 32'd10);
        step_instr("x0_done");
        check_eq("x0_zero", dut.core.RegFile.RFMem[0], 32'd0);
        step_instr("beq_done");
        check_eq("beq_pc", dut.core.fetch.pc_cur, 32'h58);
        step_instr("after_beq");
        check_eq("beq_x7", dut.core.RegFile.RFMem[7], 32'd2);
        check_eq("beq_x6_skipped", dut.core.RegFile.RFMem[6], 32'd0);
        step_instr("sub_done");
        check_eq("sub_x8", dut.core.RegFile.RFMem[8], 32'hfffffffb);
        step_instr("srai_done");
        check_eq("srai_x9", dut.core.RegFile.RFMem[9], 32'hfffffffd);
        step_instr("sltu_done");
        check_eq("sltu_x10", dut.core.RegFile.RFMem[10], 32'd1);
        step_instr("li_ab_done");
        step_instr("sb_done");
        check_eq("sb_mem", dut.memory.M[40], m40_after_sb);
        check_eq("sb_pc", dut.core.fetch.pc_cur, 32'h70);
        step_instr("li_5f7_done");
        step_instr("slli_done");
        check_eq("slli_x12", dut.core.RegFile.RFMem[12], 32'h0000bee0);
        step_instr("ori_done");
        check_eq("ori_x12", dut.core.RegFile.RFMem[12], 32'h0000beef);
        step_instr("sh_done");
        check_eq("sh_mem", dut.memory.M[40], m40_after_sh);

        // Abort a load in MEMREAD.
        wait_state(ST_MEMREAD, "abort_memread");
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_state", dut.core.control_fsm.current_state, ST_FETCH);
        check_eq("abort_pc", dut.core.fetch.pc_cur, 32'h0);
        check_eq("abort_x1", dut.core.RegFile.RFMem[1], 32'h44332211);
        @(negedge clk);
        check_eq("abort_hold_state", dut.core.control_fsm.current_state, ST_FETCH);
        reset = 1'b0;
        step_instr("restart_done");
        check_eq("restart_x1", dut.core.RegFile.RFMem[1], 32'h00000011);
        check_eq("restart_pc", dut.core.fetch.pc_cur, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/rv32_multicycle_system.md
Name: rv32_multicycle_system

Overview:
- Minimal RV32I-subset multicycle processor plus unified word-addressed instruction/data memory; the only external pins are clock and reset.
- Instructions and data are preloaded into the memory array by the testbench or backdoor.
- Core is a control FSM driving one ALU, a 32x32 register file, a PC register and one shared memory port.
- Used as the system top for ISA-level simulation, focused on loads with byte/half extraction.

Parameters:
- MEM_WORDS, 256, depth of unified memory in 32-bit words (byte address space MEM_WORDS*4).
- RESET_PC, 32'h0, PC value loaded by reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.

Behaviour:
- Reset (sampled at posedge):
  - PC = RESET_PC; FSM = FETCH; no register or memory write that cycle.
  - Register file and memory are NOT cleared, so preloaded contents survive.
  - While reset is held, FSM stays in FETCH.
  - Reset mid-instruction aborts it: no writeback, PC = RESET_PC.
- Memory:
  - Little-endian; word index = addr[log2(MEM_WORDS)+1:2]; addresses wrap modulo memory size.
  - Synchronous read: address presented in cycle N, data valid in cycle N+1.
  - Write uses byte enables.
- Register file: x0 reads 0 and ignores writes; one write port.
- FSM states (6-bit encoding) and sequences:
  - Load: FETCH -> FETCH_WAIT -> DECODE -> MEMADR -> MEMREAD -> MEMWB -> FETCH.
  - Store: ...DECODE -> MEMADR -> MEMWRITE -> FETCH.
  - OP (R-type): ...DECODE -> EXECUTER -> ALUWB -> FETCH.
  - OP-IMM: ...DECODE -> EXECUTEI -> ALUWB -> FETCH.
  - beq: ...DECODE -> BRANCH -> FETCH.
  - Unsupported opcode: DECODE -> FETCH as a NOP.
- Per-state actions:
  - FETCH: memory address = PC.
  - FETCH_WAIT: instruction register captures memory data; valid from DECODE onward.
  - DECODE: opcode, rs1/rs2/rd, funct3 and sign-extended immediate (I/S/B types) decoded; rs1/rs2 read.
  - MEMADR: ALU a = rs1 value, b = imm; out = a+b, registered as result.
  - MEMREAD: memory address = result.
  - MEMWB: data = extracted load value; result = data; rd written at the posedge leaving MEMWB.
- Load extraction by funct3, addr[1:0]:
  - lb (000) / lbu (100): byte addr[1:0] (byte0 = bits 7:0), sign- / zero-extended.
  - lh (001) / lhu (101): half chosen by addr[1] (0: bits 15:0, 1: bits 31:16), sign/zero-extended; addr[0] ignored.
  - lw (010): full word.
  - Sign bit is bit 7 / bit 15 of the selected field only.
- Store: sb/sh/sw write the low byte/half/word of rs2 into the lane chosen by addr[1:0] / addr[1]; other bytes unchanged.
- ALU ops:
  - OP: add, sub, and, or, xor, slt, sltu, sll, srl, sra.
  - OP-IMM: addi, andi, ori, xori, slti, sltiu, slli, srli, srai.
  - All 32-bit modulo.
- PC:
  - Updated on the transition into FETCH: PC+4.
  - beq taken: PC + B-imm; not taken: PC+4.
- Hierarchy exposed for verification:
  - core.control_fsm.current_state and state constants.
  - core.opcode; core.instruction_decode.rs1 and imm_ext.
  - core.alu.a, .b, .out.
  - core.result, core.data.
  - core.RegFile.RFMem[]; core.fetch.pc_cur.
  - memory.M[]; memory__address.

Optional Feature:
- Macro: STORE_EN.
- Defined: store opcode 0100011 supported via MEMWRITE.
- Undefined: stores decode as NOP (DECODE -> FETCH, PC+4, no memory change) and the MEMWRITE state/byte-enable logic is omitted.

Test Plan:
- Setup: x2 = 0x10; M[40] = 0x44332211, M[42] = 0xc7d6e5f4.
  - Signed bytes: lb x1,0x90(x2) -> x1 = 0x00000011; lb 0x98 -> 0xfffffff4; lb 0x9b -> 0xffffffc7.
  - Unsigned bytes: lbu 0x98 -> 0x000000f4; lbu 0x93 -> 0x00000044.
  - Halves: lh 0x92 -> 0x00004433; lh 0x9a -> 0xffffc7d6; lhu 0x98 -> 0x0000e5f4.
  - Per-state checks: DECODE imm = 0x90; MEMADR alu.out = 0xa0; MEMREAD memory__address = 0xa0; next FETCH x1 written and PC incremented by 4.
- Sign isolation: M[44..47] = 0x80<<0/8/16/24.
  - lb at 0xb0/0xb5/0xba/0xbf -> 0xffffff80 each.
  - lh at 0xb4 -> 0xffff8000; 0xb6 -> 0; 0xb8 -> 0; 0xba -> 0x00000080.
- Reset: hold reset 3 cycles with x2 preloaded -> state FETCH, PC 0, x2 still 0x10. Assert reset during MEMREAD -> no x1 write, PC 0.
- ALU/branch: addi x3,x0,5; add x4,x3,x3 -> x4 = 10. beq x3,x3,+8 -> PC skips one instruction. Write to x0 -> x0 stays 0.
- Stores (STORE_EN): sb of 0xAB at 0xa1 into word 0x44332211 -> 0x4433AB11. sh of 0xBEEF at 0xa2 -> 0xBEEFAB11.
